// File: rtl/clk_gen.sv
// clk_gen: divided square-wave generator with registered edge strobes and a
// wrapping count of completed periods. The output toggles once every
// HALF_PERIOD enabled clk cycles. Every output comes straight from a flop.
module clk_gen #(
    parameter int   HALF_PERIOD = 1,
    parameter int   COUNT_W     = 16,
    parameter logic START_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               clk_out,
    output logic               rise,
    output logic               fall,
    output logic [COUNT_W-1:0] cycle_count
);

    // A zero half-period has no meaning, so stop elaboration on it.
    generate
        if (HALF_PERIOD < 1) begin : g_bad_half_period
            $error("clk_gen: HALF_PERIOD must be >= 1");
        end
    endgenerate

    // The counter runs from 0 to HALF_PERIOD-1. It is kept at least 1 bit
    // wide so that HALF_PERIOD=1 still gives a legal vector.
    localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

    logic [HC_W-1:0]    hc_reg, hc_next;
    logic               clk_out_reg, clk_out_next;
    logic               rise_reg, rise_next;
    logic               fall_reg, fall_next;
    logic [COUNT_W-1:0] count_reg, count_next;

    // Terminal count: the last enabled cycle of the current half-period.
    logic terminal;
    assign terminal = en && (hc_reg == HC_LAST);

    // Next-state logic. Strobes default low and fire only on a toggle.
    always_comb begin
        hc_next      = hc_reg;
        clk_out_next = clk_out_reg;
        rise_next    = 1'b0;
        fall_next    = 1'b0;
        count_next   = count_reg;
        if (terminal) begin
            hc_next      = '0;
            clk_out_next = ~clk_out_reg;
            rise_next    = ~clk_out_reg;
            fall_next    = clk_out_reg;
            if (!clk_out_reg) begin
                count_next = count_reg + COUNT_W'(1);
            end
        end else if (en) begin
            hc_next = hc_reg + HC_W'(1);
        end
    end

    // State registers. Reset clears them immediately and raises no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_reg      <= '0;
            clk_out_reg <= START_LEVEL;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            hc_reg      <= hc_next;
            clk_out_reg <= clk_out_next;
            rise_reg    <= rise_next;
            fall_reg    <= fall_next;
            count_reg   <= count_next;
        end
    end

    assign clk_out     = clk_out_reg;
    assign rise        = rise_reg;
    assign fall        = fall_reg;
    assign cycle_count = count_reg;

endmodule

// File: tb/tb_clk_gen.sv
// tb_clk_gen: runs four clk_gen configurations side by side and checks them
// against an arithmetic model based on the number of enabled cycles since reset.
// Directed literal checks pin the model at known points.
module tb_clk_gen;

    logic clk;
    logic rst;
    logic en;

    // Instance 0: HP=1.  Instance 1: HP=3.  Instance 2: HP=1, COUNT_W=2.
    // Instance 3: HP=2, START_LEVEL=1.
    logic        out0, rise0, fall0;
    logic        out1, rise1, fall1;
    logic        out2, rise2, fall2;
    logic        out3, rise3, fall3;
    logic [15:0] cnt0, cnt1, cnt3;
    logic [1:0]  cnt2;

    clk_gen #(.HALF_PERIOD(1), .COUNT_W(16), .START_LEVEL(1'b0)) u_hp1 (
        .clk(clk), .rst(rst), .en(en),
        .clk_out(out0), .rise(rise0), .fall(fall0), .cycle_count(cnt0));
    clk_gen #(.HALF_PERIOD(3), .COUNT_W(16), .START_LEVEL(1'b0)) u_hp3 (
        .clk(clk), .rst(rst), .en(en),
        .clk_out(out1), .rise(rise1), .fall(fall1), .cycle_count(cnt1));
    clk_gen #(.HALF_PERIOD(1), .COUNT_W(2), .START_LEVEL(1'b0)) u_w2 (
        .clk(clk), .rst(rst), .en(en),
        .clk_out(out2), .rise(rise2), .fall(fall2), .cycle_count(cnt2));
    clk_gen #(.HALF_PERIOD(2), .COUNT_W(16), .START_LEVEL(1'b1)) u_sl1 (
        .clk(clk), .rst(rst), .en(en),
        .clk_out(out3), .rise(rise3), .fall(fall3), .cycle_count(cnt3));

    logic        a_out[4];
    logic        a_rise[4];
    logic        a_fall[4];
    logic [15:0] a_cnt[4];
    assign a_out[0] = out0;  assign a_rise[0] = rise0;  assign a_fall[0] = fall0;  assign a_cnt[0] = cnt0;
    assign a_out[1] = out1;  assign a_rise[1] = rise1;  assign a_fall[1] = fall1;  assign a_cnt[1] = cnt1;
    assign a_out[2] = out2;  assign a_rise[2] = rise2;  assign a_fall[2] = fall2;  assign a_cnt[2] = {14'd0, cnt2};
    assign a_out[3] = out3;  assign a_rise[3] = rise3;  assign a_fall[3] = fall3;  assign a_cnt[3] = cnt3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: everything follows from n, the count of enabled cycles since reset.
    // toggles = n / HP; level = START ^ parity(toggles);
    // rises = toggles that land on 1; strobe when a toggle just happened.
    int hp[4] = '{1, 3, 1, 2};
    int sl[4] = '{0, 0, 0, 1};
    int wd[4] = '{16, 16, 2, 16};
    int n[4];
    bit tog[4];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                n[i]   <= 0;
                tog[i] <= 1'b0;
            end else if (en) begin
                n[i]   <= n[i] + 1;
                tog[i] <= ((n[i] + 1) % hp[i]) == 0;
            end else begin
                tog[i] <= 1'b0;
            end
        end
    end

    function automatic int m_out(int i);
        return sl[i] ^ ((n[i] / hp[i]) & 1);
    endfunction

    function automatic int m_cnt(int i);
        int t;
        int r;
        t = n[i] / hp[i];
        r = (sl[i] != 0) ? (t / 2) : ((t + 1) / 2);
        return r & ((1 << wd[i]) - 1);
    endfunction

    // Every-cycle compare of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_out[%0d]", i),  a_out[i],  m_out(i));
            chk($sformatf("model_rise[%0d]", i), a_rise[i], (tog[i] && m_out(i) == 1) ? 1 : 0);
            chk($sformatf("model_fall[%0d]", i), a_fall[i], (tog[i] && m_out(i) == 0) ? 1 : 0);
            chk($sformatf("model_cnt[%0d]", i),  a_cnt[i],  m_cnt(i));
        end
    end

    // Hand-computed values after posedges 1..9 of continuous enable.
    int t_out0[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    int t_cnt0[9]  = '{1, 1, 2, 2, 3, 3, 4, 4, 5};
    int t_out1[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    int t_rise1[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    int t_fall1[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    int t_cnt1[9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 2};
    int t_cnt2[9]  = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
    int t_out3[9]  = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
    int t_cnt3[9]  = '{0, 0, 0, 1, 1, 1, 1, 2, 2};

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset state: out0=%0d out3=%0d cnt0=%0d", out0, out3, cnt0);
        chk("rst_out_hp1", out0, 0);
        chk("rst_out_sl1", out3, 1);
        chk("rst_cnt_hp3", cnt1, 0);
        chk("rst_rise_hp1", rise0, 0);

        // Continuous enable from reset: covers HP=1, HP=3, wrap and START_LEVEL=1.
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            $display("edge %0d: hp1 out=%0d cnt=%0d | hp3 out=%0d r=%0d f=%0d cnt=%0d | w2 cnt=%0d | sl1 out=%0d cnt=%0d",
                     k + 1, out0, cnt0, out1, rise1, fall1, cnt1, cnt2, out3, cnt3);
            chk($sformatf("lit_out_hp1@%0d", k + 1), out0, t_out0[k]);
            chk($sformatf("lit_cnt_hp1@%0d", k + 1), cnt0, t_cnt0[k]);
            chk($sformatf("lit_out_hp3@%0d", k + 1), out1, t_out1[k]);
            chk($sformatf("lit_rise_hp3@%0d", k + 1), rise1, t_rise1[k]);
            chk($sformatf("lit_fall_hp3@%0d", k + 1), fall1, t_fall1[k]);
            chk($sformatf("lit_cnt_hp3@%0d", k + 1), cnt1, t_cnt1[k]);
            chk($sformatf("lit_cnt_w2@%0d", k + 1), cnt2, t_cnt2[k]);
            chk($sformatf("lit_out_sl1@%0d", k + 1), out3, t_out3[k]);
            chk($sformatf("lit_cnt_sl1@%0d", k + 1), cnt3, t_cnt3[k]);
        end

        // Asynchronous reset between edges, while hp1 has clk_out=1 and cnt=5.
        #1 rst = 1'b1;
        #1;
        $display("async reset: out0=%0d cnt0=%0d out3=%0d", out0, cnt0, out3);
        chk("async_out_hp1", out0, 0);
        chk("async_cnt_hp1", cnt0, 0);
        chk("async_rise_hp1", rise0, 0);
        chk("async_fall_hp1", fall0, 0);
        chk("async_out_sl1", out3, 1);
        chk("async_cnt_hp3", cnt1, 0);
        #1 rst = 1'b0;

        // Resume from hc=0, then hold enable low mid half-period for HP=3.
        @(negedge clk);
        $display("resume 1: hp1 out=%0d rise=%0d hp3 out=%0d", out0, rise0, out1);
        chk("resume_out_hp1", out0, 1);
        chk("resume_rise_hp1", rise0, 1);
        chk("resume_out_hp3", out1, 0);
        @(negedge clk);
        chk("resume2_out_hp3", out1, 0);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            $display("hold %0d: hp3 out=%0d rise=%0d fall=%0d", k, out1, rise1, fall1);
            chk("hold_out_hp3", out1, 0);
            chk("hold_rise_hp3", rise1, 0);
            chk("hold_out_hp1", out0, 0);
        end
        en = 1'b1;
        @(negedge clk);
        $display("restore: hp3 out=%0d rise=%0d cnt=%0d", out1, rise1, cnt1);
        chk("restore_out_hp3", out1, 1);
        chk("restore_rise_hp3", rise1, 1);
        chk("restore_cnt_hp3", cnt1, 1);

        repeat (6) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
